// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared FSM encoding, default field limits and BCD helpers
package rtc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD   = 2'd1;
    localparam state_t ST_EDIT   = 2'd2;
    localparam state_t ST_COMMIT = 2'd3;

    // field 0 (day) sits in the LSBs
    localparam logic [47:0] DEF_FIELD_MIN = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    localparam logic [47:0] DEF_FIELD_MAX = {8'h59, 8'h59, 8'h23, 8'h99, 8'h12, 8'h31};

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // out-of-range or malformed values snap to lo
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (!bcd_valid(v) || v < lo || v >= hi)
            return lo;
        if (v[3:0] == 4'd9)
            return v + 8'h07;
        return v + 8'h01;
    endfunction

    // out-of-range or malformed values snap to hi
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (!bcd_valid(v) || v <= lo || v > hi)
            return hi;
        if (v[3:0] == 4'd0)
            return v - 8'h07;
        return v - 8'h01;
    endfunction

    // 20xx years only, so divisibility by 4 decides
    function automatic logic leap_bcd(input logic [7:0] y);
        if (!y[4])
            return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
        return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
        logic [7:0] d;
        case (m)
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            8'h02:                      d = leap_bcd(y) ? 8'h29 : 8'h28;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - up/down edge detect with hold-to-repeat step generation
module btn_repeat #(
    parameter int HOLD_CYCLES   = 500,
    parameter int REPEAT_CYCLES = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic btn_up,
    input  logic btn_down,
    output logic step_up,
    output logic step_down
);

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNTW = $clog2(MAXC + 1);

    logic            up_q;
    logic            down_q;
    logic [1:0]      act_q;
    logic            rep_q;
    logic [CNTW-1:0] cnt;

    logic [1:0]      act;
    logic            clr;
    logic            hit;
    logic [CNTW-1:0] target;

    // up dominates; down only counts as active while up is released
    assign act    = {btn_up, btn_down & ~btn_up};
    assign clr    = clear | (act == 2'b00) | (act != act_q);
    assign target = rep_q ? CNTW'(REPEAT_CYCLES) : CNTW'(HOLD_CYCLES);
    assign hit    = ~clr & (cnt == target);

    assign step_up   = act[1] & ((btn_up & ~up_q) | hit);
    assign step_down = act[0] & ((btn_down & ~down_q) | hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            act_q  <= 2'b00;
            rep_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            up_q   <= btn_up;
            down_q <= btn_down;
            act_q  <= act;
            if (clr) begin
                cnt   <= '0;
                rep_q <= 1'b0;
            end else if (hit) begin
                cnt   <= CNTW'(1);
                rep_q <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_field_editor.sv
// rtl/bcd_field_editor.sv - button-driven editor for packed two-digit BCD fields
module bcd_field_editor
    import rtc_pkg::*;
#(
    parameter int                   NFIELDS       = 6,
    parameter logic [8*NFIELDS-1:0] FIELD_MIN     = DEF_FIELD_MIN,
    parameter logic [8*NFIELDS-1:0] FIELD_MAX     = DEF_FIELD_MAX,
    parameter int                   HOLD_CYCLES   = 500,
    parameter int                   REPEAT_CYCLES = 100,
    parameter bit                   DATE_AWARE    = 1'b1,
    parameter int                   DAY_IDX       = 0,
    parameter int                   MON_IDX       = 1,
    parameter int                   YEAR_IDX      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn_enter,
    input  logic                       btn_exit,
    input  logic                       btn_right,
    input  logic                       btn_left,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic [8*NFIELDS-1:0]       live_values,
    output logic [8*NFIELDS-1:0]       edit_values,
    output logic [$clog2(NFIELDS)-1:0] cursor,
    output logic                       editing,
    output logic                       commit
);

    localparam int            CW      = $clog2(NFIELDS);
    localparam logic [CW-1:0] LAST    = CW'(NFIELDS - 1);
    localparam logic [CW-1:0] DAY_SEL = CW'(DAY_IDX);

    state_t state;
    logic   enter_q, exit_q, right_q, left_q;
    logic   enter_rise, exit_rise, right_rise, left_rise;
    logic   move, rep_clear, step_up, step_down;

    logic [7:0] cur_val, cur_min, cur_max, day_val, day_max;

    assign enter_rise = btn_enter & ~enter_q;
    assign exit_rise  = btn_exit & ~exit_q;
    assign right_rise = btn_right & ~right_q;
    assign left_rise  = btn_left & ~left_q;

    assign move      = (state == ST_EDIT) & ~exit_rise & (right_rise | left_rise);
    assign rep_clear = (state != ST_EDIT) | move;

    assign cur_val = edit_values[8*cursor +: 8];
    assign cur_min = FIELD_MIN[8*cursor +: 8];
    assign day_val = edit_values[8*DAY_IDX +: 8];
    assign day_max = days_in_month(edit_values[8*MON_IDX +: 8], edit_values[8*YEAR_IDX +: 8]);
    assign cur_max = (DATE_AWARE && cursor == DAY_SEL) ? day_max : FIELD_MAX[8*cursor +: 8];

    assign editing = (state != ST_IDLE);
    assign commit  = (state == ST_COMMIT);

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_btn_repeat (
        .clk       (clk),
        .reset     (reset),
        .clear     (rep_clear),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .step_up   (step_up),
        .step_down (step_down)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            edit_values <= FIELD_MIN;
            cursor      <= '0;
            enter_q     <= 1'b0;
            exit_q      <= 1'b0;
            right_q     <= 1'b0;
            left_q      <= 1'b0;
        end else begin
            enter_q <= btn_enter;
            exit_q  <= btn_exit;
            right_q <= btn_right;
            left_q  <= btn_left;
            case (state)
                ST_IDLE: begin
                    if (enter_rise)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    edit_values <= live_values;
                    cursor      <= '0;
                    state       <= ST_EDIT;
                end
                ST_EDIT: begin
                    if (exit_rise) begin
                        // clamp on the way in so the commit cycle already shows the final day
                        if (DATE_AWARE && day_val > day_max)
                            edit_values[8*DAY_IDX +: 8] <= day_max;
                        state <= ST_COMMIT;
                    end else if (right_rise) begin
                        cursor <= (cursor == LAST) ? '0 : cursor + 1'b1;
                    end else if (left_rise) begin
                        cursor <= (cursor == '0) ? LAST : cursor - 1'b1;
                    end else if (step_up) begin
                        edit_values[8*cursor +: 8] <= bcd_inc(cur_val, cur_min, cur_max);
                    end else if (step_down) begin
                        edit_values[8*cursor +: 8] <= bcd_dec(cur_val, cur_min, cur_max);
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_field_editor.sv
// tb/tb_bcd_field_editor.sv - randomized and directed bench with a decimal-arithmetic reference model
module tb_bcd_field_editor;

    localparam int          NF   = 6;
    localparam int          HOLD = 500;
    localparam int          REP  = 100;
    localparam logic [47:0] FMIN = 48'h000000000101;
    localparam logic [47:0] FMAX = 48'h595923991231;

    localparam int B_EN = 0, B_EX = 1, B_R = 2, B_L = 3, B_U = 4, B_D = 5;
    localparam int M_IDLE = 0, M_LOAD = 1, M_EDIT = 2, M_COMMIT = 3;

    logic        clk;
    logic        reset;
    logic [5:0]  btns;
    logic [47:0] live;
    logic [47:0] edit_values;
    logic [2:0]  cursor;
    logic        editing;
    logic        commit;

    int n_vec  = 0;
    int n_fail = 0;

    bcd_field_editor dut (
        .clk         (clk),
        .reset       (reset),
        .btn_enter   (btns[B_EN]),
        .btn_exit    (btns[B_EX]),
        .btn_right   (btns[B_R]),
        .btn_left    (btns[B_L]),
        .btn_up      (btns[B_U]),
        .btn_down    (btns[B_D]),
        .live_values (live),
        .edit_values (edit_values),
        .cursor      (cursor),
        .editing     (editing),
        .commit      (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: values handled as decimal numbers, timing as "cycles since the hold began"
    int         m_st  = M_IDLE;
    int         m_cur = 0;
    logic [7:0] m_val [NF];
    logic [5:0] p_btn = '0;
    int         p_act = 0;
    int         run   = 0;

    initial for (int i = 0; i < NF; i++) m_val[i] = FMIN[8*i +: 8];

    function automatic int b2d(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] d2b(input int d);
        return {4'(d / 10), 4'(d % 10)};
    endfunction

    function automatic bit is_bcd(input logic [7:0] b);
        return (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
    endfunction

    function automatic logic [7:0] mdl_day_max(input logic [7:0] mon, input logic [7:0] yr);
        int dim [13];
        int m;
        dim = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (!is_bcd(mon)) return 8'h31;
        m = b2d(mon);
        if (m < 1 || m > 12) return 8'h31;
        if (m == 2 && (b2d(yr) % 4) == 0) return 8'h29;
        return d2b(dim[m]);
    endfunction

    function automatic logic [7:0] lo_of(input int f);
        return FMIN[8*f +: 8];
    endfunction

    function automatic logic [7:0] hi_of(input int f);
        if (f == 0) return mdl_day_max(m_val[1], m_val[2]);
        return FMAX[8*f +: 8];
    endfunction

    function automatic logic [7:0] mdl_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (!is_bcd(v) || b2d(v) < b2d(lo) || b2d(v) >= b2d(hi)) return lo;
        return d2b(b2d(v) + 1);
    endfunction

    function automatic logic [7:0] mdl_dec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (!is_bcd(v) || b2d(v) <= b2d(lo) || b2d(v) > b2d(hi)) return hi;
        return d2b(b2d(v) - 1);
    endfunction

    function automatic logic [47:0] m_pack();
        logic [47:0] p;
        for (int i = 0; i < NF; i++) p[8*i +: 8] = m_val[i];
        return p;
    endfunction

    bit         r_en, r_ex, r_r, r_l, r_u, r_d, mv, hold, su, sd;
    int         act;
    logic [7:0] dm;

    always @(posedge clk) begin
        if (reset) begin
            m_st  = M_IDLE;
            m_cur = 0;
            for (int i = 0; i < NF; i++) m_val[i] = FMIN[8*i +: 8];
            p_btn = '0;
            p_act = 0;
            run   = 0;
        end else begin
            r_en = btns[B_EN] && !p_btn[B_EN];
            r_ex = btns[B_EX] && !p_btn[B_EX];
            r_r  = btns[B_R] && !p_btn[B_R];
            r_l  = btns[B_L] && !p_btn[B_L];
            r_u  = btns[B_U] && !p_btn[B_U];
            r_d  = btns[B_D] && !p_btn[B_D];
            act  = btns[B_U] ? 1 : (btns[B_D] ? 2 : 0);
            mv   = (m_st == M_EDIT) && !r_ex && (r_r || r_l);
            if (m_st != M_EDIT || mv || act == 0 || act != p_act) run = 0;
            else run = run + 1;
            hold = (run > HOLD) && (((run - HOLD - 1) % REP) == 0);
            su   = (act == 1) && (r_u || hold);
            sd   = (act == 2) && (r_d || hold);
            case (m_st)
                M_IDLE: if (r_en) m_st = M_LOAD;
                M_LOAD: begin
                    for (int i = 0; i < NF; i++) m_val[i] = live[8*i +: 8];
                    m_cur = 0;
                    m_st  = M_EDIT;
                end
                M_EDIT: begin
                    if (r_ex) begin
                        dm = mdl_day_max(m_val[1], m_val[2]);
                        if (m_val[0] > dm) m_val[0] = dm;
                        m_st = M_COMMIT;
                    end else if (r_r) m_cur = (m_cur + 1) % NF;
                    else if (r_l) m_cur = (m_cur + NF - 1) % NF;
                    else if (su) m_val[m_cur] = mdl_inc(m_val[m_cur], lo_of(m_cur), hi_of(m_cur));
                    else if (sd) m_val[m_cur] = mdl_dec(m_val[m_cur], lo_of(m_cur), hi_of(m_cur));
                end
                default: m_st = M_IDLE;
            endcase
            p_btn = btns;
            p_act = act;
        end
    end

    always @(negedge clk) begin : cmp
        logic [47:0] mp;
        mp = m_pack();
        n_vec++;
        if (edit_values !== mp || cursor !== 3'(m_cur) ||
            editing !== (m_st != M_IDLE) || commit !== (m_st == M_COMMIT)) begin
            n_fail++;
            $display("FAIL cycle@%0t: vals=%h cur=%0d ed=%b cm=%b, model vals=%h cur=%0d ed=%b cm=%b",
                     $time, edit_values, cursor, editing, commit,
                     mp, m_cur, (m_st != M_IDLE), (m_st == M_COMMIT));
        end
    end

    task automatic lit(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int b);
        btns[b] = 1'b1;
        cyc(1);
        btns[b] = 1'b0;
        cyc(1);
    endtask

    initial begin
        btns  = '0;
        live  = '0;
        reset = 1'b1;
        cyc(3);
        lit("reset_vals", edit_values, FMIN);
        lit("reset_cursor", cursor, 0);
        lit("reset_editing", editing, 0);
        lit("reset_commit", commit, 0);
        reset = 1'b0;
        cyc(1);

        // snapshot: enter edge, LOAD, EDIT sees exit, commit on the third edge
        live = 48'h593012240215;
        btns[B_EN] = 1'b1; cyc(1);
        lit("load_editing", editing, 1);
        btns[B_EN] = 1'b0; cyc(1);
        btns[B_EX] = 1'b1; cyc(1);
        lit("snap_commit", commit, 1);
        lit("snap_vals", edit_values, 48'h593012240215);
        lit("snap_vals_model", m_pack(), 48'h593012240215);
        btns[B_EX] = 1'b0; cyc(1);
        lit("commit_one_cycle", commit, 0);
        lit("idle_editing", editing, 0);
        lit("idle_vals_hold", edit_values, 48'h593012240215);

        // hour wrap, cursor wrap, hold-right, February leap clamp
        live = 48'h000023240131;
        pulse(B_EN);
        repeat (3) pulse(B_R);
        lit("cursor_hour", cursor, 3);
        pulse(B_U);
        lit("hour_up_wrap", edit_values[31:24], 8'h00);
        pulse(B_D);
        lit("hour_down_wrap", edit_values[31:24], 8'h23);
        repeat (3) pulse(B_L);
        pulse(B_L);
        lit("cursor_left_wrap", cursor, 5);
        pulse(B_R);
        lit("cursor_right_wrap", cursor, 0);
        btns[B_R] = 1'b1; cyc(1000);
        btns[B_R] = 1'b0; cyc(1);
        lit("cursor_hold_once", cursor, 1);
        pulse(B_U);
        lit("month_feb", edit_values[15:8], 8'h02);
        btns[B_EX] = 1'b1; cyc(1);
        lit("leap_commit", commit, 1);
        lit("leap_day", edit_values[7:0], 8'h29);
        lit("leap_day_model", {56'h0, m_val[0]}, 8'h29);
        btns[B_EX] = 1'b0; cyc(1);

        // day down wrap in April, BCD borrow on hour
        live = 48'h000010230401;
        pulse(B_EN);
        pulse(B_D);
        lit("april_day_wrap", edit_values[7:0], 8'h30);
        repeat (3) pulse(B_R);
        pulse(B_D);
        lit("bcd_borrow", edit_values[31:24], 8'h09);
        pulse(B_EX);

        // auto-repeat then non-leap clamp
        live = 48'h000000230131;
        pulse(B_EN);
        repeat (3) pulse(B_R);
        btns[B_U] = 1'b1; cyc(HOLD + 2 * REP + 1);
        btns[B_U] = 1'b0; cyc(1);
        lit("auto_repeat", edit_values[31:24], 8'h03);
        lit("auto_repeat_model", {56'h0, m_val[3]}, 8'h03);
        repeat (2) pulse(B_L);
        pulse(B_U);
        btns[B_EX] = 1'b1; cyc(1);
        lit("nonleap_commit", commit, 1);
        lit("nonleap_day", edit_values[7:0], 8'h28);
        btns[B_EX] = 1'b0; cyc(1);

        // invalid load, then reset mid-session
        live = 48'h0000002401AF;
        pulse(B_EN);
        pulse(B_U);
        lit("invalid_up_min", edit_values[7:0], 8'h01);
        reset = 1'b1; cyc(1);
        lit("midreset_editing", editing, 0);
        lit("midreset_commit", commit, 0);
        lit("midreset_vals", edit_values, FMIN);
        reset = 1'b0; cyc(1);

        for (int i = 0; i < 30000; i++) begin
            live = {$urandom, $urandom};
            live[23:16] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 3) != 0) live[15:8] = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 3) != 0) live[7:0] = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 199) == 0) btns[B_EN] = ~btns[B_EN];
            if ($urandom_range(0, 299) == 0) btns[B_EX] = ~btns[B_EX];
            if ($urandom_range(0, 59) == 0) btns[B_R] = ~btns[B_R];
            if ($urandom_range(0, 59) == 0) btns[B_L] = ~btns[B_L];
            if ($urandom_range(0, 299) == 0) btns[B_U] = ~btns[B_U];
            if ($urandom_range(0, 299) == 0) btns[B_D] = ~btns[B_D];
            if ($urandom_range(0, 4999) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
